// File: rtl/capture_engine_pkg.sv
// capture_engine_pkg: shared trigger-mode and FSM state encodings for the capture engine
package capture_engine_pkg;
  typedef enum logic [2:0] {
    TRIG_RISE, TRIG_FALL, TRIG_EDGE, TRIG_HIGH, TRIG_LOW, TRIG_PAT, TRIG_IMM
  } trig_mode_e;
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE
  } state_e;
endpackage

// File: rtl/capture_engine_trigger_unit.sv
// capture_engine_trigger_unit: combinational trigger hit detection
//   mode/ch/mask/pat : latched trigger configuration (mode 7 behaves as immediate)
//   sample           : sample currently being written
//   prev, prev_vld   : previously written sample and whether one exists since arming
//   hit              : trigger condition satisfied by sample
module capture_engine_trigger_unit
  import capture_engine_pkg::*;
#(
  parameter int CH   = 4,
  parameter int CH_W = 2
) (
  input  logic [2:0]      mode,
  input  logic [CH_W-1:0] ch,
  input  logic [CH-1:0]   mask,
  input  logic [CH-1:0]   pat,
  input  logic [CH-1:0]   sample,
  input  logic [CH-1:0]   prev,
  input  logic            prev_vld,
  output logic            hit
);
  logic [CH_W-1:0] sel;
  logic cur, old, rise, fall;
  always_comb begin
    sel  = (32'(ch) < CH) ? ch : '0;
    cur  = sample[sel];
    old  = prev[sel];
    // no edge can be seen until a sample has been stored since arming
    rise = prev_vld & ~old & cur;
    fall = prev_vld & old & ~cur;
    hit  = mode == TRIG_RISE ? rise :
           mode == TRIG_FALL ? fall :
           mode == TRIG_EDGE ? rise | fall :
           mode == TRIG_HIGH ? cur :
           mode == TRIG_LOW  ? ~cur :
           mode == TRIG_PAT  ? ((sample ^ pat) & mask) == '0 :
           1'b1;
  end
endmodule

// File: rtl/capture_engine.sv
// capture_engine: N-channel logic-analyser capture core with circular pre-trigger buffer
//   clk65, reset          : system clock, asynchronous active-high reset
//   smpl_en, datain       : sample strobe and synchronised channel inputs
//   start, abort          : arm capture (from IDLE/DONE), return to IDLE
//   trig_mode/ch/mask/pat : trigger configuration, latched at arm
//   pre_len               : samples kept before the trigger, latched at arm
//   rd_en, rd_idx         : trigger-aligned read request, 0 = oldest sample
//   rd_data, rd_valid     : read result one cycle after rd_en (zero unless DONE)
//   busy, write_finish    : capturing / buffer frozen and readable
//   trig_pos              : logical index of the trigger sample
module capture_engine
  import capture_engine_pkg::*;
#(
  parameter int CH     = 4,
  parameter int ADDR_W = 13,
  parameter int CH_W   = 2
) (
  input  logic              clk65,
  input  logic              reset,
  input  logic              smpl_en,
  input  logic [CH-1:0]     datain,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        trig_mode,
  input  logic [CH_W-1:0]   trig_ch,
  input  logic [CH-1:0]     trig_mask,
  input  logic [CH-1:0]     trig_pat,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [CH-1:0]     rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              write_finish,
  output logic [ADDR_W-1:0] trig_pos
);
  state_e state;
  logic [ADDR_W-1:0] wr_ptr, pre_cnt, post_cnt, start_addr, cfg_pre, raddr;
  logic [2:0] cfg_mode;
  logic [CH_W-1:0] cfg_ch;
  logic [CH-1:0] cfg_mask, cfg_pat, prev, ram_q;
  logic prev_vld, hit, we, rd_ok;
  logic [CH-1:0] mem [2**ADDR_W];

  assign busy         = state inside {S_PRE, S_ARMED, S_POST};
  assign write_finish = state == S_DONE;
  assign trig_pos     = cfg_pre;
  assign we           = smpl_en && busy && !abort;
  assign raddr        = start_addr + rd_idx;
  assign rd_data      = rd_ok ? ram_q : '0;

  capture_engine_trigger_unit #(.CH(CH), .CH_W(CH_W)) trig (
    .mode(cfg_mode), .ch(cfg_ch), .mask(cfg_mask), .pat(cfg_pat),
    .sample(datain), .prev(prev), .prev_vld(prev_vld), .hit(hit)
  );

  // pre_len is ADDR_W wide, so it can never exceed DEPTH-1 and needs no clamp
  always_ff @(posedge clk65 or posedge reset)
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      start_addr <= '0;
      cfg_pre    <= '0;
      cfg_mode   <= '0;
      cfg_ch     <= '0;
      cfg_mask   <= '0;
      cfg_pat    <= '0;
      prev       <= '0;
      prev_vld   <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
    end else if (start && !busy) begin
      // with no pre-history requested the very first sample is already armed
      state    <= pre_len == '0 ? S_ARMED : S_PRE;
      cfg_pre  <= pre_len;
      cfg_mode <= trig_mode;
      cfg_ch   <= trig_ch;
      cfg_mask <= trig_mask;
      cfg_pat  <= trig_pat;
      pre_cnt  <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (we) begin
      wr_ptr   <= wr_ptr + 1'b1;
      prev     <= datain;
      prev_vld <= 1'b1;
      if (state == S_PRE) begin
        pre_cnt <= pre_cnt + 1'b1;
        if (ADDR_W'(pre_cnt + 1'b1) == cfg_pre) state <= S_ARMED;
      end else if (state == S_ARMED && hit) begin
        start_addr <= wr_ptr - cfg_pre;
        post_cnt   <= ~cfg_pre;
        state      <= cfg_pre == '1 ? S_DONE : S_POST;
      end else if (state == S_POST) begin
        post_cnt <= post_cnt - 1'b1;
        if (post_cnt == ADDR_W'(1)) state <= S_DONE;
      end
    end

  always_ff @(posedge clk65 or posedge reset)
    if (reset) begin
      rd_valid <= 1'b0;
      rd_ok    <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_ok    <= rd_en && state == S_DONE;
    end

  always_ff @(posedge clk65) begin
    if (we) mem[wr_ptr] <= datain;
    if (rd_en) ram_q <= mem[raddr];
  end
endmodule

// File: tb/tb_capture_engine.sv
// tb_capture_engine: scenario tasks plus a read-data scoreboard for capture_engine
module tb_capture_engine;
  logic clk = 0, reset = 1, smpl_en = 0, start = 0, abort = 0, rd_en = 0;
  logic [3:0] datain = 0, trig_mask = 0, trig_pat = 0, rd_data;
  logic [2:0] trig_mode = 0;
  logic [1:0] trig_ch = 0;
  logic [5:0] pre_len = 0, rd_idx = 0, trig_pos;
  logic rd_valid, busy, write_finish;
  logic [3:0] smp [256];
  logic [3:0] exp_q [$];
  int checks = 0, errors = 0;

  capture_engine #(.CH(4), .ADDR_W(6), .CH_W(2)) dut (
    .clk65(clk), .reset(reset), .smpl_en(smpl_en), .datain(datain), .start(start), .abort(abort),
    .trig_mode(trig_mode), .trig_ch(trig_ch), .trig_mask(trig_mask), .trig_pat(trig_pat),
    .pre_len(pre_len), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .write_finish(write_finish), .trig_pos(trig_pos)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected rd_valid with rd_data %0h, nothing expected", rd_data);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL sb_rd_data got %0h exp %0h", rd_data, e);
        end
      end
    end

  task automatic arm(input int pre, input logic [2:0] mode, input logic [1:0] ch, input logic [3:0] mask, pat);
    pre_len = 6'(pre); trig_mode = mode; trig_ch = ch; trig_mask = mask; trig_pat = pat;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    trig_mode = 3'd6; trig_ch = 2'd3; trig_mask = 4'h0; trig_pat = 4'hf; pre_len = 6'd0;
  endtask

  task automatic feed(input int duty, input int start_at, output int fed, output bit done);
    int ph = 0;
    fed = 0;
    for (int cyc = 0; cyc < 1000 && write_finish !== 1'b1; cyc++) begin
      smpl_en = ph == 0;
      datain = smpl_en ? smp[fed % 256] : 4'($urandom);
      start = smpl_en && fed == start_at;
      @(posedge clk); #1;
      if (smpl_en) fed++;
      ph = ph + 1 == duty ? 0 : ph + 1;
    end
    smpl_en = 0; start = 0;
    done = write_finish === 1'b1;
  endtask

  task automatic read_buf(input int first);
    for (int i = 0; i < 64; i++) begin
      rd_en = 1; rd_idx = 6'(i);
      exp_q.push_back(smp[first + i]);
      @(posedge clk); #1;
    end
    rd_en = 0;
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic finish_checks(input string nm, input int fed, input bit done, input int exp_fed, input int exp_pos);
    checks++; if (!done) begin errors++; $display("FAIL %s_timeout write_finish got 0 exp 1", nm); end
    checks++; if (fed != exp_fed) begin errors++; $display("FAIL %s_writes got %0d exp %0d", nm, fed, exp_fed); end
    checks++; if (trig_pos !== 6'(exp_pos)) begin errors++; $display("FAIL %s_trig_pos got %0d exp %0d", nm, trig_pos, exp_pos); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %0b exp 0", nm, busy); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    checks++; if ({busy, write_finish, rd_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, write_finish, rd_valid}); end
    checks++; if (trig_pos !== 6'd0 || rd_data !== 4'd0) begin errors++; $display("FAIL reset_values trig_pos %0d rd_data %0h exp 0 0", trig_pos, rd_data); end
    reset = 0;
    rd_en = 1; rd_idx = 6'd5; exp_q.push_back(4'h0);
    @(posedge clk); #1;
    rd_en = 0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL idle_rd_valid got %b exp 1", rd_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_edge;
    int fed; bit done;
    for (int i = 0; i < 256; i++) smp[i] = 4'(((i * 2) & 14) | (i >= 40 ? 1 : 0));
    arm(10, 3'd0, 2'd0, 4'h0, 4'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL edge_busy got %b exp 1", busy); end
    feed(1, -1, fed, done);
    finish_checks("edge", fed, done, 94, 10);
    read_buf(30);
  endtask

  task automatic test_pattern;
    int fed; bit done;
    for (int i = 0; i < 256; i++) smp[i] = 4'((i + 14) % 16);
    arm(10, 3'd5, 2'd0, 4'b1010, 4'b1000);
    feed(1, -1, fed, done);
    finish_checks("pattern", fed, done, 64, 10);
    read_buf(0);
  endtask

  task automatic test_immediate;
    int fed; bit done;
    for (int i = 0; i < 256; i++) smp[i] = 4'($urandom);
    arm(0, 3'd6, 2'd0, 4'h0, 4'h0);
    feed(1, -1, fed, done);
    finish_checks("imm_pre0", fed, done, 64, 0);
    read_buf(0);
    arm(63, 3'd7, 2'd0, 4'h0, 4'h0);
    feed(1, -1, fed, done);
    finish_checks("imm_pre63", fed, done, 64, 63);
    read_buf(0);
    smp[0] = 4'b0010; smp[1] = 4'b0000; smp[2] = 4'b0010;
    arm(0, 3'd0, 2'd1, 4'h0, 4'h0);
    feed(1, -1, fed, done);
    finish_checks("edge_first", fed, done, 66, 0);
    read_buf(2);
  endtask

  task automatic test_wrap;
    int fed; bit done;
    for (int i = 0; i < 256; i++) smp[i] = 4'(i % 16);
    arm(60, 3'd1, 2'd3, 4'h0, 4'h0);
    feed(1, -1, fed, done);
    finish_checks("wrap", fed, done, 68, 60);
    read_buf(4);
  endtask

  task automatic test_duty;
    int fed; bit done;
    for (int i = 0; i < 256; i++) smp[i] = 4'((i + 14) % 16);
    arm(10, 3'd5, 2'd0, 4'b1010, 4'b1000);
    feed(3, 30, fed, done);
    finish_checks("duty", fed, done, 64, 10);
    read_buf(0);
  endtask

  task automatic test_abort;
    for (int i = 0; i < 256; i++) smp[i] = 4'((i + 14) % 16);
    arm(10, 3'd5, 2'd0, 4'b1010, 4'b1000);
    smpl_en = 1;
    for (int i = 0; i < 20; i++) begin datain = smp[i]; @(posedge clk); #1; end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    checks++; if ({busy, write_finish} !== 2'b00) begin errors++; $display("FAIL abort_state got %b exp 00", {busy, write_finish}); end
    repeat (80) @(posedge clk);
    #1;
    smpl_en = 0;
    checks++; if ({busy, write_finish} !== 2'b00) begin errors++; $display("FAIL abort_hold got %b exp 00", {busy, write_finish}); end
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_priority busy got %b exp 0", busy); end
    arm(20, 3'd5, 2'd0, 4'h0, 4'h0);
    smpl_en = 1;
    repeat (4) @(posedge clk);
    #1;
    rd_en = 1;
    @(posedge clk); #1;
    rd_en = 0; smpl_en = 0;
    checks++; if (busy !== 1'b1 || trig_pos !== 6'd20 || rd_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got busy %b trig_pos %0d rd_valid %b exp 1 20 1", busy, trig_pos, rd_valid); end
    #2 reset = 1;
    #1;
    checks++; if ({busy, write_finish, rd_valid} !== 3'b000) begin errors++; $display("FAIL async_flags got %b exp 000", {busy, write_finish, rd_valid}); end
    checks++; if (trig_pos !== 6'd0 || rd_data !== 4'd0) begin errors++; $display("FAIL async_values trig_pos %0d rd_data %0h exp 0 0", trig_pos, rd_data); end
    @(posedge clk); #1;
    reset = 0;
    rd_en = 1; rd_idx = 6'd0; exp_q.push_back(4'h0);
    @(posedge clk); #1;
    rd_en = 0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL post_reset_rd_valid got %b exp 1", rd_valid); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_edge;
    test_pattern;
    test_immediate;
    test_wrap;
    test_duty;
    test_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
